// File: rtl/data_serializer.sv
// Parallel-to-serial stage: emits NO_CH channels LSB chunk first, SER_BW bits per cycle,
// with a one-word pending register. Define DATA_SERIALIZER_RELU_EN to clamp negatives to 0.
module data_serializer #(
   parameter int unsigned NO_CH  = 10,
   parameter int unsigned BW_IN  = 12,
   parameter int unsigned SER_BW = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           vld_in,
   input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
   output logic                           vld_out,
   output logic [NO_CH-1:0][SER_BW-1:0]   data_out,
   output logic                           busy,
   output logic                           ovf
);

   localparam int unsigned NO_CYC = BW_IN / SER_BW;
   localparam int unsigned CNT_W  = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;

   if (BW_IN % SER_BW != 0) begin : g_bw_chk
      $error("data_serializer: BW_IN must be a multiple of SER_BW");
   end

   typedef logic [NO_CH-1:0][BW_IN-1:0] word_t;
   typedef enum logic {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   word_t            sh_q, sh_d;
   word_t            pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic [CNT_W-1:0] cntr_q, cntr_d;
   logic             ovf_q, ovf_d;
   logic             last_chunk;

   // Conditioning applied whenever a word enters sh or pend.
   function automatic word_t prep(input word_t w);
      word_t r;
      r = w;
`ifdef DATA_SERIALIZER_RELU_EN
      for (int unsigned i = 0; i < NO_CH; i++) begin
         if (w[i][BW_IN-1]) r[i] = '0;
      end
`endif
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         sh_q     <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         cntr_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         cntr_q   <= cntr_d;
         ovf_q    <= ovf_d;
      end
   end

   assign last_chunk = (state_q == StShift) && (cntr_q == CNT_W'(NO_CYC - 1));

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      cntr_d   = cntr_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (vld_in) begin
               sh_d    = prep(data_in);
               cntr_d  = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (last_chunk) begin
               // Pending word has priority; a simultaneous input refills pend.
               if (pend_v_q) begin
                  sh_d   = pend_q;
                  cntr_d = '0;
                  if (vld_in) pend_d = prep(data_in);
                  else        pend_v_d = 1'b0;
               end else if (vld_in) begin
                  sh_d   = prep(data_in);
                  cntr_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               for (int unsigned i = 0; i < NO_CH; i++) begin
                  sh_d[i] = sh_q[i] >> SER_BW;
               end
               cntr_d = cntr_q + CNT_W'(1);
               if (vld_in) begin
                  if (!pend_v_q) begin
                     pend_d   = prep(data_in);
                     pend_v_d = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_comb begin
      vld_out  = (state_q == StShift);
      data_out = '0;
      for (int unsigned i = 0; i < NO_CH; i++) begin
         if (state_q == StShift) data_out[i] = sh_q[i][SER_BW-1:0];
      end
      busy = (state_q == StShift) | pend_v_q;
      ovf  = ovf_q;
   end

endmodule
